multicycle_controller: RTL and testbench

//  Multi-cycle sequencer for the RV32I-subset datapath: Moore FSM that steps each instruction through

---
 rtl/multicycle_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I-subset sequencer: steps one instruction at a time through fetch/decode/execute/
// memory/writeback, with a memory req/ready watchdog, retired-instruction counter and sticky fault code.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             func75,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic [1:0]       fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam int         WAIT_W   = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_FAULT
  } state_t;

  state_t             state_reg, state_next;
  logic [WAIT_W-1:0]  wait_reg, wait_next;
  logic [CNT_W-1:0]   instret_reg;
  logic [1:0]         fault_reg, fault_next;
  logic               is_store_reg, is_store_next;
  logic               timeout;
  logic               alu_ok;
  logic [2:0]         alu_ctl;

  // The wait counter reads k-1 during the k-th cycle of a memory wait.
  assign timeout = (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));
  assign instret = instret_reg;
  assign fault   = fault_reg;

  always_comb begin
    alu_ok  = 1'b1;
    alu_ctl = 3'b000;
    case (funct3)
      3'b000:  alu_ctl = (opcode == OP_R && func75) ? 3'b001 : 3'b000;
      3'b010:  alu_ctl = 3'b101;
      3'b110:  alu_ctl = 3'b011;
      3'b111:  alu_ctl = 3'b010;
      default: alu_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      wait_reg     <= '0;
      instret_reg  <= '0;
      fault_reg    <= 2'b00;
      is_store_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_reg     <= wait_next;
      fault_reg    <= fault_next;
      is_store_reg <= is_store_next;
      if (instr_done)
        instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next    = state_reg;
    fault_next    = fault_reg;
    is_store_next = is_store_reg;
    wait_next     = '0;
    mem_req       = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = 3'b000;
    ResultSrc     = 2'b00;
    ImmSrc        = 2'b00;
    instr_done    = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_FAULT;
          fault_next = 2'b10;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (opcode)
          OP_LOAD:  begin state_next = S_MEMADR; is_store_next = 1'b0; end
          OP_STORE: begin state_next = S_MEMADR; is_store_next = 1'b1; end
          OP_R:     state_next = S_EXECR;
          OP_I:     state_next = S_EXECI;
          OP_B:     state_next = S_BRANCH;
          OP_JAL:   state_next = S_JAL;
          default:  begin state_next = S_FAULT; fault_next = 2'b01; end
        endcase
      end
      // Load/store direction was captured in DECODE so opcode is not needed here.
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = is_store_reg ? 2'b01 : 2'b00;
        state_next = is_store_reg ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (timeout) begin
          state_next = S_FAULT;
          fault_next = 2'b10;
        end
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next = S_FAULT;
          fault_next = 2'b10;
        end
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (state_reg == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_ctl;
        if (alu_ok) begin
          state_next = S_ALUWB;
        end else begin
          state_next = S_FAULT;
          fault_next = 2'b01;
        end
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        case (funct3)
          3'b000: begin PCWrite = Zero;  instr_done = 1'b1; state_next = S_FETCH; end
          3'b001: begin PCWrite = !Zero; instr_done = 1'b1; state_next = S_FETCH; end
          default: begin state_next = S_FAULT; fault_next = 2'b01; end
        endcase
      end
      // ALUOut still holds the jump target from DECODE; the ALU forms PC+4 for the link write.
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_FAULT: ;
      default: ;
    endcase

    if (state_next == state_reg &&
        (state_reg == S_FETCH || state_reg == S_MEMREAD || state_reg == S_MEMWRITE))
      wait_next = wait_reg + WAIT_W'(1);

    if (rst) begin
      mem_req    = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
      ResultSrc  = 2'b00;
      ImmSrc     = 2'b00;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: builds a per-cycle expected trace from instruction-level rules and checks every cycle.
module tb_multicycle_controller;
  localparam int TO = 16;
  localparam int CW = 4;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011;
  localparam logic [6:0] II = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic func75 = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, instr_done;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, fault;
  logic [2:0] ALUControl;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .func75(func75), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .instr_done(instr_done), .instret(instret), .fault(fault));

  typedef struct {
    bit rstv; bit mr; bit zero;
    logic [6:0] opc; logic [2:0] f3; bit f75;
    logic [19:0] val; logic [19:0] care;
    logic [CW-1:0] cnt; bit chk_cnt;
    logic [63:0] tag;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  bit have = 1'b0;
  int n_cmp = 0, n_bad = 0, cycno = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [1:0] m_fault = 2'b00;

  // Output vector: mem_req,AdrSrc,IRWrite,PCWrite,MemWrite,RegWrite,ALUSrcA,ALUSrcB,ALUControl,ResultSrc,ImmSrc,instr_done,fault
  function automatic logic [19:0] ov(input bit mr, input bit adr, input bit irw, input bit pcw,
      input bit mw, input bit rw, input logic [1:0] asa, input logic [1:0] asb,
      input logic [2:0] alu, input logic [1:0] rs, input logic [1:0] imm, input bit done);
    return {mr, adr, irw, pcw, mw, rw, asa, asb, alu, rs, imm, done, m_fault};
  endfunction

  function automatic logic [19:0] cm(input bit adr, input bit asa, input bit asb,
      input bit alu, input bit rs, input bit imm);
    return {1'b1, adr, 4'b1111, {2{asa}}, {2{asb}}, {3{alu}}, {2{rs}}, {2{imm}}, 1'b1, 2'b11};
  endfunction

  task automatic push(input logic [19:0] v, input logic [19:0] c, input bit mr, input bit z,
      input bit real_in, input logic [6:0] opc, input logic [2:0] f3, input bit f75,
      input logic [63:0] tag);
    cyc_t r;
    r.rstv = 1'b0; r.mr = mr; r.zero = z;
    if (real_in) begin
      r.opc = opc; r.f3 = f3; r.f75 = f75;
    end else begin
      r.opc = 7'($urandom); r.f3 = 3'($urandom); r.f75 = 1'($urandom);
    end
    r.val = v; r.care = c; r.cnt = m_cnt; r.chk_cnt = 1'b1; r.tag = tag;
    q.push_back(r);
  endtask

  function automatic bit rnd();
    return 1'($urandom);
  endfunction

  task automatic t_rst();
    cyc_t r;
    r.rstv = 1'b1; r.mr = rnd(); r.zero = rnd(); r.opc = 7'h7F; r.f3 = 3'b011; r.f75 = 1'b1;
    r.val = 20'h0; r.care = 20'hFFFFC; r.cnt = m_cnt; r.chk_cnt = 1'b0; r.tag = "rst1";
    q.push_back(r);
    m_fault = 2'b00; m_cnt = '0;
    r.val = 20'h0; r.care = 20'hFFFFF; r.cnt = m_cnt; r.chk_cnt = 1'b1; r.tag = "rst2";
    q.push_back(r);
  endtask

  task automatic t_fetch(input bit mr);
    push(ov(1'b1, 1'b0, mr, mr, 1'b0, 1'b0, 2'd0, 2'd2, 3'd0, 2'd2, 2'd0, 1'b0),
         cm(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0), mr, rnd(), 1'b0, 7'h0, 3'h0, 1'b0, "fetch");
  endtask

  task automatic t_dead(input int n);
    for (int i = 0; i < n; i++)
      push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0),
           cm(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), rnd(), rnd(), 1'b0, 7'h0, 3'h0, 1'b0, "faulted");
  endtask

  task automatic t_memread(input bit mr);
    push(ov(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0),
         cm(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), mr, rnd(), 1'b0, 7'h0, 3'h0, 1'b0, "memread");
  endtask

  task automatic t_aluwb();
    push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b1),
         cm(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), rnd(), rnd(), 1'b0, 7'h0, 3'h0, 1'b0, "aluwb");
    m_cnt = m_cnt + 1'b1;
  endtask

  // One instruction from fetch to retire (or to its fault), with fwait/mwait cycles of mem_ready=0.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input bit f75,
      input bit z, input int fwait, input int mwait);
    bit legal, take;
    logic [2:0] alu;
    for (int i = 0; i < fwait; i++) t_fetch(1'b0);
    t_fetch(1'b1);
    push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 3'd0, 2'd0, 2'd2, 1'b0),
         cm(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), rnd(), rnd(), 1'b1, opc, f3, f75, "decode");
    case (opc)
      LD, ST: begin
        push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, (opc == ST) ? 2'd1 : 2'd0, 1'b0),
             cm(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), rnd(), rnd(), 1'b0, 7'h0, 3'h0, 1'b0, "memadr");
        if (opc == LD) begin
          for (int i = 0; i < mwait; i++) t_memread(1'b0);
          t_memread(1'b1);
          push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd1, 2'd0, 1'b1),
               cm(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), rnd(), rnd(), 1'b0, 7'h0, 3'h0, 1'b0, "memwb");
          m_cnt = m_cnt + 1'b1;
        end else begin
          for (int i = 0; i <= mwait; i++)
            push(ov(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, i == mwait),
                 cm(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), i == mwait, rnd(), 1'b0, 7'h0, 3'h0, 1'b0, "memwrite");
          m_cnt = m_cnt + 1'b1;
        end
      end
      RR, II: begin
        legal = 1'b1; alu = 3'd0;
        case (f3)
          3'b000: alu = (opc == RR && f75) ? 3'd1 : 3'd0;
          3'b010: alu = 3'd5;
          3'b110: alu = 3'd3;
          3'b111: alu = 3'd2;
          default: legal = 1'b0;
        endcase
        push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, (opc == II) ? 2'd1 : 2'd0, alu, 2'd0, 2'd0, 1'b0),
             cm(1'b0, 1'b1, 1'b1, legal, 1'b0, opc == II), rnd(), rnd(), 1'b1, opc, f3, f75, "exec");
        if (legal) t_aluwb();
        else begin m_fault = 2'b01; t_dead(8); end
      end
      BR: begin
        legal = (f3 == 3'b000 || f3 == 3'b001);
        take = (f3 == 3'b000) ? z : !z;
        push(ov(1'b0, 1'b0, 1'b0, legal && take, 1'b0, 1'b0, 2'd2, 2'd0, 3'd1, 2'd0, 2'd0, legal),
             cm(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0), rnd(), z, 1'b1, opc, f3, f75, "branch");
        if (legal) m_cnt = m_cnt + 1'b1;
        else begin m_fault = 2'b01; t_dead(8); end
      end
      JL: begin
        push(ov(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 3'd0, 2'd0, 2'd0, 1'b0),
             cm(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0), rnd(), rnd(), 1'b0, 7'h0, 3'h0, 1'b0, "jal");
        t_aluwb();
      end
      default: begin m_fault = 2'b01; t_dead(20); end
    endcase
  endtask

  task automatic chk(input logic [63:0] name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %0s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Wait until every queued cycle has been applied and its clock edge has passed.
  task automatic drain();
    int budget = 3000;
    do begin
      @(posedge clk);
      budget--;
    end while (q.size() != 0 && budget > 0);
    #1;
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d cycles left, required 0", q.size());
    end
  endtask

  initial begin : driver
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        cur = q.pop_front();
        have = 1'b1;
        rst = cur.rstv; mem_ready = cur.mr; Zero = cur.zero;
        opcode = cur.opc; funct3 = cur.f3; func75 = cur.f75;
      end else begin
        have = 1'b0;
      end
    end
  end

  initial begin : compare
    logic [19:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (have) begin
        cycno++;
        act = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ALUSrcA, ALUSrcB,
               ALUControl, ResultSrc, ImmSrc, instr_done, fault};
        n_cmp++;
        if ((act & cur.care) !== (cur.val & cur.care)) begin
          n_bad++;
          $display("FAIL %0s cycle %0d: outputs %h, required %h (care %h)", cur.tag, cycno, act, cur.val, cur.care);
        end
        if (cur.chk_cnt) begin
          n_cmp++;
          if (instret !== cur.cnt) begin
            n_bad++;
            $display("FAIL instret %0s cycle %0d: got %0d, required %0d", cur.tag, cycno, instret, cur.cnt);
          end
        end
      end
    end
  end

  initial begin : main
    int n0;
    t_rst();
    n0 = q.size(); run_instr(RR, 3'b000, 1'b0, 1'b0, 0, 0); chk("add_len", q.size() - n0, 4);
    drain();
    $display("add x3,x1,x2: instret=%0d fault=%0d", instret, fault);
    chk("add_cnt", int'(instret), 1); chk("add_flt", int'(fault), 0);

    run_instr(RR, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(RR, 3'b110, 1'b0, 1'b0, 0, 0);
    run_instr(RR, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(II, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(II, 3'b111, 1'b0, 1'b0, 1, 0);
    drain();
    $display("sub/or/slt/addi/andi: instret=%0d", instret);
    chk("alu_cnt", int'(instret), 6);

    n0 = q.size(); run_instr(LD, 3'b010, 1'b0, 1'b0, 0, 3); chk("lw_slow_len", q.size() - n0, 8);
    run_instr(ST, 3'b010, 1'b0, 1'b0, 0, 2);
    n0 = q.size(); run_instr(ST, 3'b010, 1'b0, 1'b0, 0, 0); chk("sw_len", q.size() - n0, 4);
    n0 = q.size(); run_instr(JL, 3'b000, 1'b0, 1'b0, 0, 0); chk("jal_len", q.size() - n0, 4);
    n0 = q.size(); run_instr(LD, 3'b010, 1'b0, 1'b0, 0, 0); chk("lw_len", q.size() - n0, 5);
    drain();
    $display("lw/sw/jal: instret=%0d", instret);
    chk("mem_cnt", int'(instret), 11);

    n0 = q.size(); run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0); chk("beq_len", q.size() - n0, 3);
    run_instr(BR, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(BR, 3'b001, 1'b0, 1'b1, 0, 0);
    run_instr(BR, 3'b001, 1'b0, 1'b0, 0, 0);
    drain();
    $display("beq/bne: instret=%0d", instret);
    chk("br_cnt", int'(instret), 15);

    run_instr(RR, 3'b000, 1'b0, 1'b0, TO - 1, 0);
    drain();
    $display("ready on last watchdog cycle: instret=%0d fault=%0d", instret, fault);
    chk("wrap_cnt", int'(instret), 0); chk("edge_flt", int'(fault), 0);

    run_instr(RR, 3'b001, 1'b0, 1'b0, 0, 0);
    drain();
    $display("bad R funct3: fault=%0d", fault);
    chk("exec_flt", int'(fault), 1); chk("exec_cnt", int'(instret), 0);

    t_rst(); run_instr(RR, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0);
    drain();
    $display("illegal opcode: fault=%0d instret=%0d", fault, instret);
    chk("opc_flt", int'(fault), 1); chk("opc_cnt", int'(instret), 1);

    t_rst();
    drain();
    $display("reset after fault: fault=%0d instret=%0d", fault, instret);
    chk("rst_flt", int'(fault), 0); chk("rst_cnt", int'(instret), 0);

    for (int i = 0; i < TO; i++) t_fetch(1'b0);
    m_fault = 2'b10; t_dead(5);
    drain();
    $display("fetch timeout: fault=%0d", fault);
    chk("fto_flt", int'(fault), 2);

    t_rst(); run_instr(BR, 3'b100, 1'b0, 1'b1, 0, 0);
    drain();
    $display("bad branch funct3: fault=%0d instret=%0d", fault, instret);
    chk("br_flt", int'(fault), 1); chk("br_noret", int'(instret), 0);

    t_rst(); run_instr(RR, 3'b111, 1'b0, 1'b0, 0, 0);
    t_fetch(1'b1);
    push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 3'd0, 2'd0, 2'd2, 1'b0),
         cm(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1, LD, 3'b010, 1'b0, "decode");
    push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, 2'd0, 1'b0),
         cm(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 7'h0, 3'h0, 1'b0, "memadr");
    for (int i = 0; i < TO; i++) t_memread(1'b0);
    m_fault = 2'b10; t_dead(4);
    drain();
    $display("memread timeout: fault=%0d instret=%0d", fault, instret);
    chk("mto_flt", int'(fault), 2); chk("mto_cnt", int'(instret), 1);

    t_rst(); t_fetch(1'b1);
    push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 3'd0, 2'd0, 2'd2, 1'b0),
         cm(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1, LD, 3'b010, 1'b0, "decode");
    push(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, 2'd0, 1'b0),
         cm(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 7'h0, 3'h0, 1'b0, "memadr");
    t_memread(1'b0);
    t_rst(); run_instr(RR, 3'b000, 1'b0, 1'b0, 0, 0);
    drain();
    $display("reset mid-lw then add: instret=%0d fault=%0d", instret, fault);
    chk("abort_cnt", int'(instret), 1); chk("abort_flt", int'(fault), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
